// File: rtl/perf_halt_monitor.sv
// Event counter bank with self-branch halt detection for the mp3 pipeline.
// Counters freeze once the program spins on a self-branch, so their values reflect the program run.
module perf_halt_monitor #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter bit SATURATE     = 1'b1,
  parameter int HALT_CONFIRM = 2,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              pause_i,
  input  logic [31:0]       pc_cur_i,
  input  logic [31:0]       pc_next_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_ovf_o,
  output logic              halt_o,
  output logic              halt_pulse_o
);

  typedef enum logic {ST_RUN, ST_HALTED} halt_state_t;

  localparam logic [3:0] CONFIRM_LAST = 4'(HALT_CONFIRM - 1);

  halt_state_t       state_q, state_d;
  logic [3:0]        run_cnt_q, run_cnt_d;
  logic              pulse_d;
  logic              loop_c;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic [CNT_W-1:0]  sel_cnt;
  logic              sel_ovf;

  assign loop_c = (pc_cur_i == pc_next_i) && !pause_i;
  assign halt_o = (state_q == ST_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      run_cnt_q    <= '0;
      halt_pulse_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      halt_pulse_o <= pulse_d;
    end
  end

  // The confirmation run only advances while not yet halted; any break restarts it.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    pulse_d   = 1'b0;
    if (clear_i) begin
      state_d   = ST_RUN;
      run_cnt_d = '0;
    end else if (!loop_c) begin
      run_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      run_cnt_d = run_cnt_q + 4'd1;
      if (run_cnt_q == CONFIRM_LAST) begin
        state_d = ST_HALTED;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clear_i) begin
          cnt_q[i] <= '0;
          ovf_q[i] <= 1'b0;
        end else if (enable_i && !halt_o && event_i[i]) begin
          if (cnt_q[i] == {CNT_W{1'b1}}) begin
            ovf_q[i] <= 1'b1;
            if (!SATURATE) cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Selects that match no channel fall through to zero.
  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        sel_cnt = cnt_q[i];
        sel_ovf = ovf_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_o <= '0;
      rd_ovf_o  <= 1'b0;
    end else begin
      rd_data_o <= sel_cnt;
      rd_ovf_o  <= sel_ovf;
    end
  end

endmodule

// File: tb/tb_perf_halt_monitor.sv
// Bench for perf_halt_monitor: three instances (32-bit, 8-bit saturating, 8-bit wrapping) share stimulus
// and are compared against an event-count model that derives each width's expected readout.
module tb_perf_halt_monitor;

  localparam int HC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        pause_i = 1'b0;
  logic [3:0]  event_i = '0;
  logic [31:0] pc_cur_i = 32'h0;
  logic [31:0] pc_next_i = 32'h4;
  logic [1:0]  rd_sel_i = '0;

  logic [31:0] rd_data_32;
  logic [7:0]  rd_data_s8, rd_data_w8;
  logic        ovf_32, ovf_s8, ovf_w8;
  logic        halt_32, halt_s8, halt_w8;
  logic        pulse_32, pulse_s8, pulse_w8;

  perf_halt_monitor #(.NUM_CH(4), .CNT_W(32), .SATURATE(1'b1), .HALT_CONFIRM(HC)) u_dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .clear_i(clear_i), .event_i(event_i),
    .pause_i(pause_i), .pc_cur_i(pc_cur_i), .pc_next_i(pc_next_i), .rd_sel_i(rd_sel_i),
    .rd_data_o(rd_data_32), .rd_ovf_o(ovf_32), .halt_o(halt_32), .halt_pulse_o(pulse_32));

  perf_halt_monitor #(.NUM_CH(4), .CNT_W(8), .SATURATE(1'b1), .HALT_CONFIRM(HC)) u_sat8 (
    .clk(clk), .rst(rst), .enable_i(enable_i), .clear_i(clear_i), .event_i(event_i),
    .pause_i(pause_i), .pc_cur_i(pc_cur_i), .pc_next_i(pc_next_i), .rd_sel_i(rd_sel_i),
    .rd_data_o(rd_data_s8), .rd_ovf_o(ovf_s8), .halt_o(halt_s8), .halt_pulse_o(pulse_s8));

  perf_halt_monitor #(.NUM_CH(4), .CNT_W(8), .SATURATE(1'b0), .HALT_CONFIRM(HC)) u_wrap8 (
    .clk(clk), .rst(rst), .enable_i(enable_i), .clear_i(clear_i), .event_i(event_i),
    .pause_i(pause_i), .pc_cur_i(pc_cur_i), .pc_next_i(pc_next_i), .rd_sel_i(rd_sel_i),
    .rd_data_o(rd_data_w8), .rd_ovf_o(ovf_w8), .halt_o(halt_w8), .halt_pulse_o(pulse_w8));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: true number of counted events per channel since the last clear/reset.
  longint m_cnt [4];
  longint m_rd;
  bit     m_halt, m_pulse;
  int     m_streak;

  task automatic model_reset();
    for (int c = 0; c < 4; c++) m_cnt[c] = 0;
    m_rd = 0;
    m_halt = 1'b0;
    m_pulse = 1'b0;
    m_streak = 0;
  endtask

  task automatic model_edge();
    bit loop_now;
    bit was_halted;
    m_rd = m_cnt[rd_sel_i];
    loop_now = (pc_cur_i == pc_next_i) && !pause_i;
    was_halted = m_halt;
    m_pulse = 1'b0;
    if (clear_i) begin
      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
      m_halt = 1'b0;
      m_streak = 0;
    end else begin
      for (int c = 0; c < 4; c++)
        if (enable_i && !was_halted && event_i[c]) m_cnt[c]++;
      if (!was_halted) begin
        m_streak = loop_now ? m_streak + 1 : 0;
        if (m_streak >= HC) begin
          m_halt = 1'b1;
          m_pulse = 1'b1;
        end
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    longint sat, wrp;
    sat = (m_rd > 255) ? 255 : m_rd;
    wrp = m_rd % 256;
    check_output("rd32", {32'h0, rd_data_32}, 64'(m_rd & 64'hFFFF_FFFF));
    check_output("ovf32", {63'h0, ovf_32}, {63'h0, (m_rd > 64'hFFFF_FFFF)});
    check_output("rd_sat8", {56'h0, rd_data_s8}, 64'(sat));
    check_output("ovf_sat8", {63'h0, ovf_s8}, {63'h0, (m_rd > 255)});
    check_output("rd_wrap8", {56'h0, rd_data_w8}, 64'(wrp));
    check_output("ovf_wrap8", {63'h0, ovf_w8}, {63'h0, (m_rd > 255)});
    check_output("halt", {61'h0, halt_32, halt_s8, halt_w8}, {61'h0, {3{m_halt}}});
    check_output("pulse", {61'h0, pulse_32, pulse_s8, pulse_w8}, {61'h0, {3{m_pulse}}});
  endtask

  task automatic apply_stimulus(input int n);
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    #11 rst = 1'b0;

    // Plain counting on channels 0 and 2, then readout of each channel
    enable_i = 1'b1;
    event_i = 4'b0101;
    apply_stimulus(10);
    event_i = 4'b0000;
    rd_sel_i = 2'd2;
    apply_stimulus(1);
    check_output("t1_ch2", {32'h0, rd_data_32}, 64'd10);
    rd_sel_i = 2'd1;
    apply_stimulus(1);
    check_output("t1_ch1", {32'h0, rd_data_32}, 64'd0);
    rd_sel_i = 2'd0;
    apply_stimulus(1);
    check_output("t1_ch0", {32'h0, rd_data_32}, 64'd10);

    // 300 events on channel 1: saturation versus wrap on the 8-bit instances
    clear_i = 1'b1;
    apply_stimulus(1);
    clear_i = 1'b0;
    event_i = 4'b0010;
    apply_stimulus(300);
    event_i = 4'b0000;
    rd_sel_i = 2'd1;
    apply_stimulus(1);
    check_output("t2_sat8", {56'h0, rd_data_s8}, 64'd255);
    check_output("t2_sat8_ovf", {63'h0, ovf_s8}, 64'd1);
    check_output("t2_wrap8", {56'h0, rd_data_w8}, 64'd44);
    check_output("t2_wrap8_ovf", {63'h0, ovf_w8}, 64'd1);
    check_output("t2_rd32", {32'h0, rd_data_32}, 64'd300);

    // Self-branch halt after two clean cycles; later events are ignored
    clear_i = 1'b1;
    apply_stimulus(1);
    clear_i = 1'b0;
    pc_cur_i = 32'h6000_0040;
    pc_next_i = 32'h6000_0040;
    event_i = 4'b1111;
    apply_stimulus(1);
    check_output("t3_halt_e1", {63'h0, halt_32}, 64'd0);
    apply_stimulus(1);
    check_output("t3_halt_e2", {63'h0, halt_32}, 64'd1);
    check_output("t3_pulse_e2", {63'h0, pulse_32}, 64'd1);
    apply_stimulus(1);
    check_output("t3_pulse_e3", {63'h0, pulse_32}, 64'd0);
    apply_stimulus(3);
    pc_next_i = 32'h6000_0044;
    event_i = 4'b0000;
    rd_sel_i = 2'd3;
    apply_stimulus(2);
    check_output("t3_frozen", {32'h0, rd_data_32}, 64'd2);
    check_output("t3_halt_held", {63'h0, halt_32}, 64'd1);

    // Clear while halted with all events high, then counting resumes
    clear_i = 1'b1;
    event_i = 4'b1111;
    apply_stimulus(1);
    check_output("t5_halt_clr", {63'h0, halt_32}, 64'd0);
    check_output("t5_pulse_clr", {63'h0, pulse_32}, 64'd0);
    clear_i = 1'b0;
    rd_sel_i = 2'd0;
    apply_stimulus(1);
    check_output("t5_cleared", {32'h0, rd_data_32}, 64'd0);
    apply_stimulus(2);
    event_i = 4'b0000;
    rd_sel_i = 2'd3;
    apply_stimulus(1);
    check_output("t5_resumed", {32'h0, rd_data_32}, 64'd3);

    // A pause inside the run restarts confirmation
    pc_next_i = 32'h6000_0040;
    apply_stimulus(1);
    pause_i = 1'b1;
    apply_stimulus(1);
    pause_i = 1'b0;
    apply_stimulus(1);
    check_output("t4_halt_e3", {63'h0, halt_32}, 64'd0);
    apply_stimulus(1);
    check_output("t4_halt_e4", {63'h0, halt_32}, 64'd1);
    check_output("t4_pulse_e4", {63'h0, pulse_32}, 64'd1);
    apply_stimulus(1);

    // Asynchronous reset mid-count
    pc_next_i = 32'h6000_0044;
    clear_i = 1'b1;
    apply_stimulus(1);
    clear_i = 1'b0;
    event_i = 4'b0001;
    apply_stimulus(7);
    event_i = 4'b0000;
    rd_sel_i = 2'd0;
    apply_stimulus(2);
    check_output("t6_before_rst", {32'h0, rd_data_32}, 64'd7);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_output("t6_async_rd", {32'h0, rd_data_32}, 64'd0);
    check_all();
    #1 rst = 1'b0;
    apply_stimulus(1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      enable_i = ($urandom_range(7) != 0);
      clear_i = ($urandom_range(39) == 0);
      pause_i = ($urandom_range(3) == 0);
      event_i = 4'($urandom);
      rd_sel_i = 2'($urandom);
      pc_cur_i = ($urandom_range(1) != 0) ? 32'h100 : 32'h104;
      pc_next_i = ($urandom_range(1) != 0) ? 32'h100 : 32'h104;
      apply_stimulus(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perf_halt_monitor.md
# perf_halt_monitor

Synthesisable performance-counter bank with built-in infinite-loop halt detection for the mp3 pipeline. It counts up to NUM_CH single-bit event strobes, such as cache hits/misses, stalls and retired instructions. It detects the self-branch end-of-program condition (next PC equals the current PC while the pipeline is not paused) and freezes all counters at halt, so the values reflect exactly the program run. Instantiated inside mp3 next to the datapath. The testbench and debug logic read it through a registered select/read port.

## Interface
- NUM_CH, 4, number of event counters (1..16)
- CNT_W, 32, counter width in bits (8..64)
- SATURATE, 1, 1 = counters stick at all-ones on overflow; 0 = wrap to zero
- HALT_CONFIRM, 2, consecutive qualifying cycles required before halt (1..15)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable_i  in  1  global count enable
- clear_i  in  1  synchronous clear of counters, overflow flags and halt state
- event_i  in  NUM_CH  per-channel event strobe, one count per cycle when high
- pause_i  in  1  pipeline pause/stall; halt detection is suppressed while high
- pc_cur_i  in  32  PC of the instruction in EX/MEM
- pc_next_i  in  32  PC-mux output (next fetch PC)
- rd_sel_i  in  max(1,$clog2(NUM_CH))  channel select for readout
- rd_data_o  out  CNT_W  registered counter value of the selected channel
- rd_ovf_o  out  1  registered sticky overflow flag of the selected channel
- halt_o  out  1  sticky halt indication
- halt_pulse_o  out  1  single-cycle pulse on the halt rising edge

## Operation
- Loop condition: loop_c = (pc_cur_i == pc_next_i) & ~pause_i.
- run_cnt (4 bit) increments on each cycle where loop_c holds and halt is low. It resets to 0 on any cycle with loop_c low, including a pause cycle.
- Halt triggers when loop_c holds and run_cnt == HALT_CONFIRM-1. halt_o and halt_pulse_o go high at the next edge. halt_pulse_o drops after one cycle, and halt_o holds until rst or clear_i.
- Counter update per channel i on each edge, in priority order:
  - clear_i → 0.
  - Else if enable_i & ~halt_o & event_i[i]: cnt+1.
    - At all-ones with SATURATE=1: value held and ovf[i] set.
    - At all-ones with SATURATE=0: wraps to 0 and ovf[i] set.
- Events in the triggering cycle, where halt_o is still low, are counted. Events from the first cycle with halt_o high onward are not.
- ovf[i] is sticky and is cleared only by rst or clear_i.
- clear_i also zeroes run_cnt and halt_o and suppresses halt_pulse_o. A halt trigger in the same cycle as clear_i is discarded.
- Readout: rd_data_o / rd_ovf_o <= cnt[rd_sel_i] / ovf[rd_sel_i] every cycle. An out-of-range select returns 0 / 0.
- Readout works regardless of enable_i and halt_o.

## Timing
- Reset values (asynchronous): all counters 0, all ovf 0, run_cnt 0, halt_o 0, halt_pulse_o 0, rd_data_o 0, rd_ovf_o 0.
- Event to counter: 1 cycle. Counter to rd_data_o: 1 further cycle. An event at edge t is visible on rd_data_o after edge t+2, for an unchanged select.
- Halt latency: with loop_c high on cycles t .. t+HALT_CONFIRM-1, halt_o is high after edge t+HALT_CONFIRM.
- A pause cycle inside the run restarts the confirmation count.
- Reset asserted mid-run or after halt: all state returns to reset values immediately, with no clock required.
- Reset deassertion is assumed synchronised externally. The first active edge after release behaves as a normal cycle.

## Test plan
- Reset, then NUM_CH=4, event_i=4'b0101 for 10 cycles with enable_i=1 → ch0=10, ch1=0, ch2=10, ch3=0. rd_sel_i=2 gives rd_data_o=10 one cycle later.
- CNT_W=8, SATURATE=1, 300 events on ch1 → ch1=255, rd_ovf_o=1. Repeat with SATURATE=0 → ch1=44, ovf=1.
- HALT_CONFIRM=2, pc_cur_i=pc_next_i=0x60000040 with pause_i=0 for 2 cycles → halt_pulse_o high for exactly one cycle on the 2nd edge after run start, and halt_o stays high. Events after that edge do not change the counters.
- Same PCs, but pause_i=1 on the 2nd cycle, then 2 clean cycles → halt asserts only after the final 2 clean cycles (edge 4 from run start).
- After halt, assert clear_i for one cycle while event_i=4'b1111 → all counters 0, halt_o 0, no halt_pulse_o. Counting resumes on the next cycle.
- Assert rst for half a cycle mid-count with ch0=7 → ch0 and rd_data_o read 0 before the next clk edge.
